// File: rtl/cpu_run_ctrl.sv
// Run sequencer for the CPU top: owns the core reset line, releases it after a
// fixed pulse, filters the halt signal and times the run with a watchdog.
module cpu_run_ctrl #(
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned DONE_STABLE = 2,
    parameter int unsigned CW          = 16,
    parameter int unsigned TIMEOUT     = 16'd50000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          cpu_done,
    output logic          cpu_reset,
    output logic          busy,
    output logic          finished,
    output logic          timed_out,
    output logic [CW-1:0] cycle_count
);

    localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned SW = $clog2(DONE_STABLE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [RW-1:0] rst_cnt;
    logic [CW-1:0] run_cnt;
    logic [CW-1:0] start_cnt;
    logic [SW-1:0] streak;

    logic [SW-1:0] streak_nxt_c;
    logic [CW-1:0] start_cnt_nxt_c;
    logic          halt_c;
    logic          tmo_c;
    logic          cpu_reset_nxt;
    logic          busy_nxt;
    logic          finished_nxt;
    logic          timed_out_nxt;

    // Halt filter: streak saturates at DONE_STABLE; start_cnt latches on each rise
    always_comb begin
        streak_nxt_c    = '0;
        start_cnt_nxt_c = start_cnt;
        if (cpu_done) begin
            streak_nxt_c = (streak == SW'(DONE_STABLE)) ? streak : streak + SW'(1);
            if (streak == '0) begin
                start_cnt_nxt_c = run_cnt;
            end
        end
        halt_c = (streak_nxt_c == SW'(DONE_STABLE));
        tmo_c  = (run_cnt == CW'(TIMEOUT));
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            finished  <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            cpu_reset <= cpu_reset_nxt;
            busy      <= busy_nxt;
            finished  <= finished_nxt;
            timed_out <= timed_out_nxt;
        end
    end

    // Next-state logic; halt qualification beats the watchdog on the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (start) begin
                    state_nxt = S_RESET;
                end
            end
            S_RESET: begin
                if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (halt_c) begin
                    state_nxt = S_DONE;
                end else if (tmo_c) begin
                    state_nxt = S_TIMEOUT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state; a halted core stays out of reset
    always_comb begin
        cpu_reset_nxt = 1'b1;
        busy_nxt      = 1'b0;
        finished_nxt  = 1'b0;
        timed_out_nxt = 1'b0;
        case (state_nxt)
            S_RESET: busy_nxt = 1'b1;
            S_RUN: begin
                cpu_reset_nxt = 1'b0;
                busy_nxt      = 1'b1;
            end
            S_DONE: begin
                cpu_reset_nxt = 1'b0;
                finished_nxt  = 1'b1;
            end
            S_TIMEOUT: timed_out_nxt = 1'b1;
            default: ;
        endcase
    end

    // Counters and cycle_count
    always_ff @(posedge clk) begin
        if (reset) begin
            rst_cnt     <= '0;
            run_cnt     <= '0;
            start_cnt   <= '0;
            streak      <= '0;
            cycle_count <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_TIMEOUT: begin
                    if (start) begin
                        rst_cnt     <= '0;
                        run_cnt     <= '0;
                        start_cnt   <= '0;
                        streak      <= '0;
                        cycle_count <= '0;
                    end
                end
                S_RESET: begin
                    if (state_nxt == S_RUN) begin
                        run_cnt     <= CW'(1);
                        cycle_count <= CW'(1);
                    end else begin
                        rst_cnt <= rst_cnt + RW'(1);
                    end
                end
                S_RUN: begin
                    streak    <= streak_nxt_c;
                    start_cnt <= start_cnt_nxt_c;
                    if (halt_c) begin
                        cycle_count <= start_cnt_nxt_c;
                    end else if (tmo_c) begin
                        cycle_count <= CW'(TIMEOUT);
                    end else begin
                        run_cnt     <= run_cnt + CW'(1);
                        cycle_count <= run_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: per-run outcome predicted from the
// cpu_done pattern as "first window of DS consecutive highs within TMO cycles".
module tb_cpu_run_ctrl;

    localparam int unsigned RST = 4;
    localparam int unsigned DS  = 2;
    localparam int unsigned CW  = 16;
    localparam int unsigned TMO = 100;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          cpu_done;
    logic          cpu_reset;
    logic          busy;
    logic          finished;
    logic          timed_out;
    logic [CW-1:0] cycle_count;

    int checks = 0;
    int errors = 0;
    bit pat [1:TMO];

    cpu_run_ctrl #(
        .RST_CYCLES (RST),
        .DONE_STABLE(DS),
        .CW         (CW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cpu_done   (cpu_done),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .finished   (finished),
        .timed_out  (timed_out),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic cr, input logic bz,
                            input logic fn, input logic to, input int cc);
        chk({tag, ".cpu_reset"},   32'(cpu_reset),   32'(cr));
        chk({tag, ".busy"},        32'(busy),        32'(bz));
        chk({tag, ".finished"},    32'(finished),    32'(fn));
        chk({tag, ".timed_out"},   32'(timed_out),   32'(to));
        chk({tag, ".cycle_count"}, 32'(cycle_count), 32'(cc));
    endtask

    task automatic clear_pat();
        for (int k = 1; k <= int'(TMO); k++) pat[k] = 1'b0;
    endtask

    // One run from a parked state; abort_at>0 asserts reset during that RUN cycle
    task automatic do_run(input string tag, input int abort_at);
        int  end_n;
        int  exp_cc;
        int  run;
        bit  is_done;
        end_n   = TMO;
        exp_cc  = TMO;
        is_done = 1'b0;
        run     = 0;
        for (int k = 1; k <= int'(TMO); k++) begin
            run = pat[k] ? run + 1 : 0;
            if (run == int'(DS)) begin
                end_n   = k;
                exp_cc  = k - int'(DS) + 1;
                is_done = 1'b1;
                break;
            end
        end

        start    = 1'b1;
        cpu_done = 1'($urandom);
        @(negedge clk);
        start = 1'b0;
        for (int r = 1; r <= int'(RST); r++) begin
            chk_outs({tag, ".rst"}, 1'b1, 1'b1, 1'b0, 1'b0, 0);
            cpu_done = 1'($urandom);
            start    = (r == 2) || ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        for (int k = 1; k <= end_n; k++) begin
            chk_outs({tag, ".run"}, 1'b0, 1'b1, 1'b0, 1'b0, k);
            if (k == abort_at) begin
                start = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk_outs({tag, ".abort"}, 1'b1, 1'b0, 1'b0, 1'b0, 0);
                @(negedge clk);
                chk_outs({tag, ".abort_idle"}, 1'b1, 1'b0, 1'b0, 1'b0, 0);
                return;
            end
            cpu_done = pat[k];
            start    = (k == 5) || ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_outs({tag, ".end"}, !is_done, 1'b0, is_done, !is_done, exp_cc);
            cpu_done = 1'($urandom);
            @(negedge clk);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        cpu_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_outs("in_reset", 1'b1, 1'b0, 1'b0, 1'b0, 0);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cpu_done = 1'($urandom);
            @(negedge clk);
            chk_outs("idle", 1'b1, 1'b0, 1'b0, 1'b0, 0);
        end

        clear_pat();
        for (int k = 37; k <= int'(TMO); k++) pat[k] = 1'b1;
        do_run("normal", 0);

        clear_pat();
        pat[10] = 1'b1;
        for (int k = 20; k <= int'(TMO); k++) pat[k] = 1'b1;
        do_run("glitch", 0);

        clear_pat();
        do_run("watchdog", 0);

        clear_pat();
        for (int k = 37; k <= int'(TMO); k++) pat[k] = 1'b1;
        do_run("rerun_after_tmo", 0);
        do_run("rerun_after_done", 0);

        clear_pat();
        pat[TMO-1] = 1'b1;
        pat[TMO]   = 1'b1;
        do_run("done_vs_tmo", 0);

        clear_pat();
        pat[TMO] = 1'b1;
        do_run("late_rise", 0);

        clear_pat();
        for (int k = 1; k <= int'(TMO); k++) pat[k] = 1'b1;
        do_run("immediate", 0);

        clear_pat();
        for (int k = 30; k <= int'(TMO); k++) pat[k] = 1'b1;
        do_run("abort", 15);

        for (int it = 0; it < 8; it++) begin
            int npulse;
            clear_pat();
            npulse = $urandom_range(0, 6);
            for (int p = 0; p < npulse; p++) begin
                int pos;
                int len;
                pos = $urandom_range(1, TMO);
                len = $urandom_range(1, 3);
                for (int j = pos; j < pos + len && j <= int'(TMO); j++) pat[j] = 1'b1;
            end
            do_run("random", 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
